axi_lite_bus_arbiter: RTL
=========================

// Module: axi_lite_bus_arbiter
// PURPOSE
//   Shares the single AXI4-Lite master port of the core (MMU bus) between two requesters:
//   req 0 = load/store unit, req 1 = boot loader / debug port.
//   Each requester uses a simple req/ack interface. The block serialises accesses:
//   one outstanding transaction at a time, granted round-robin.
//   Sits between the core's memory stage and the AXI interconnect.
// PARAMETERS
//   ADDR_W    32      address width (both requesters and AXI)
//   DATA_W    32      data width; wstrb width is DATA_W/8
//   RR_EN     1       1 = round-robin grant; 0 = fixed priority, req 0 always wins
//   PROT_VAL  3'b000  constant driven on axi_arprot/axi_awprot
// PORTS
//   clk            in   1         single clock; all logic on posedge
//   rst            in   1         asynchronous, active-high reset
//   req            in   2         per-requester request, level; bit i = requester i
//   req_we         in   2         1 = write, 0 = read; sampled at grant only
//   req_addr       in   2*ADDR_W  packed, [i*ADDR_W +: ADDR_W]; sampled at grant
//   req_wdata      in   2*DATA_W  packed; sampled at grant
//   req_wstrb      in   2*DATA_W/8 packed; sampled at grant
//   ack            out  2         one-cycle completion pulse to the granted requester
//   rsp_rdata      out  DATA_W    read data; valid while ack is high, held until next ack
//   rsp_resp       out  2         AXI resp of the completed access; valid with ack
//   busy           out  1         high from grant until the ack cycle (inclusive)
//   axi_araddr/arvalid/arprot  out     ADDR_W/1/3  AR channel; axi_arready in 1
//   axi_rready                 out     1           R channel; axi_rdata/rresp/rvalid in DATA_W/2/1
//   axi_awaddr/awvalid/awprot  out     ADDR_W/1/3  AW channel; axi_awready in 1
//   axi_wdata/wstrb/wvalid     out     DATA_W/DATA_W/8/1  W channel; axi_wready in 1
//   axi_bready                 out     1           B channel; axi_bresp/bvalid in 2/1
// BEHAVIOUR
//   Reset (async, any state):
//   - state=IDLE; last_grant=1 (so req 0 wins the first tie)
//   - all valid/ready/ack outputs 0; addr/data/rsp regs 0; busy 0
//   States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
//   - IDLE: if req!=0, pick grant. RR_EN=1: the requester other than last_grant when both
//     are high, else the single one. RR_EN=0: lowest index.
//   - On grant, latch we/addr/wdata/wstrb of the grantee; update last_grant; busy<=1.
//     Go to RD_ADDR (we=0) or WR_REQ (we=1). No AXI output is driven combinationally from req.
//   - RD_ADDR: arvalid=1 with latched addr. On arvalid&arready -> RD_DATA, arvalid<=0.
//   - RD_DATA: rready=1. On rvalid&rready latch rdata/rresp -> DONE, rready<=0.
//   - WR_REQ: awvalid and wvalid both raised on entry. Each drops independently on its own
//     handshake (AW and W may complete in either order or the same cycle). Once both are done
//     -> WR_RESP.
//   - WR_RESP: bready=1. On bvalid latch bresp into rsp_resp; rsp_rdata unchanged -> DONE.
//   - DONE: ack[grant]=1 for exactly one cycle, busy=1 -> IDLE (busy<=0).
//     req is not sampled in DONE.
//   Latency, zero-wait slave: read = grant edge + 1 (AR) + 1 (R) + 1 (DONE) = ack 3 cycles
//   after the cycle req is seen in IDLE; write likewise.
//   Requester rule: hold req high until ack, drop it on the ack edge. req still high in the
//   cycle after ack is a new request.
//   req dropped before ack: ignored. The transaction completes on AXI and ack is still pulsed.
//   AXI rules: once asserted, valid is held until handshake; addr/data are stable while valid.
//   rresp/bresp SLVERR/DECERR are passed through in rsp_resp; no retry.
//   Never more than one AXI transaction outstanding; AR and AW are never both valid.
//   Reset mid-transaction abandons it; no ack is issued.
// TESTING
//   1. Read, req0 only, addr 0x100, slave rdata 0xDEADBEEF, zero wait
//      -> arvalid cycle 1; ack=2'b01 at cycle 3; rsp_rdata=0xDEADBEEF; rsp_resp=0.
//   2. Write, req1, addr 0x200, wdata 0x12345678, wstrb 4'b0011; awready 2 cycles before wready
//      -> awvalid drops first; wvalid held until its handshake; one bready handshake;
//         ack=2'b10 once.
//   3. Both req high continuously, RR_EN=1, 4 accesses
//      -> grant order 0,1,0,1; never two acks in one cycle.
//      Same with RR_EN=0 -> req 0 granted every time.
//   4. rvalid with rresp=2'b10 after a 5-cycle stall
//      -> rready held high during the stall; rsp_resp=2'b10 with ack.
//   5. Assert rst while in WR_RESP
//      -> all outputs 0 next cycle, no ack; a following req0 read completes normally.
//   6. req0 dropped in RD_DATA
//      -> read still completes; ack[0] pulses once; state returns to IDLE.

Source files
------------

// File: rtl/axi_lite_bus_arbiter.sv
// Two-requester req/ack front end onto one AXI4-Lite master port.
// Accesses are serialised, with one outstanding at a time and round-robin or fixed-priority grant.
module axi_lite_bus_arbiter #(
   parameter int          ADDR_W   = 32,
   parameter int          DATA_W   = 32,
   parameter int          RR_EN    = 1,
   parameter logic [2:0]  PROT_VAL = 3'b000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              req,
   input  logic [1:0]              req_we,
   input  logic [2*ADDR_W-1:0]     req_addr,
   input  logic [2*DATA_W-1:0]     req_wdata,
   input  logic [2*(DATA_W/8)-1:0] req_wstrb,
   output logic [1:0]              ack,
   output logic [DATA_W-1:0]       rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    busy,
   output logic [ADDR_W-1:0]       axi_araddr,
   output logic                    axi_arvalid,
   output logic [2:0]              axi_arprot,
   input  logic                    axi_arready,
   output logic                    axi_rready,
   input  logic [DATA_W-1:0]       axi_rdata,
   input  logic [1:0]              axi_rresp,
   input  logic                    axi_rvalid,
   output logic [ADDR_W-1:0]       axi_awaddr,
   output logic                    axi_awvalid,
   output logic [2:0]              axi_awprot,
   input  logic                    axi_awready,
   output logic [DATA_W-1:0]       axi_wdata,
   output logic [DATA_W/8-1:0]     axi_wstrb,
   output logic                    axi_wvalid,
   input  logic                    axi_wready,
   output logic                    axi_bready,
   input  logic [1:0]              axi_bresp,
   input  logic                    axi_bvalid,
   output logic [2:0]              dbg_state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_REQ  = 3'd3,
      WR_RESP = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic                  grant_q, last_grant_q, pick;
   logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic [ADDR_W-1:0]     addr_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [DATA_W/8-1:0]   wstrb_q;
   logic                  grant_now;

   // When both request, round-robin hands the grant to the one not served last.
   always_comb begin
      pick = 1'b0;
      if ((RR_EN != 0) && (req == 2'b11)) begin
         pick = ~last_grant_q;
      end else if (!req[0]) begin
         pick = 1'b1;
      end
   end

   assign grant_now = (state_q == IDLE) && (req != 2'b00);

   always_comb begin
      state_d   = state_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      case (state_q)
         IDLE: begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            if (grant_now) begin
               state_d = req_we[pick] ? WR_REQ : RD_ADDR;
            end
         end
         RD_ADDR: if (axi_arready) state_d = RD_DATA;
         RD_DATA: if (axi_rvalid)  state_d = DONE;
         WR_REQ: begin
            aw_done_d = aw_done_q | axi_awready;
            w_done_d  = w_done_q  | axi_wready;
            if (aw_done_d && w_done_d) state_d = WR_RESP;
         end
         WR_RESP: if (axi_bvalid) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         rsp_rdata    <= '0;
         rsp_resp     <= '0;
      end else begin
         state_q   <= state_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         if (grant_now) begin
            grant_q      <= pick;
            last_grant_q <= pick;
            addr_q       <= pick ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
            wdata_q      <= pick ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
            wstrb_q      <= pick ? req_wstrb[2*(DATA_W/8)-1:DATA_W/8] : req_wstrb[DATA_W/8-1:0];
         end
         if ((state_q == RD_DATA) && axi_rvalid) begin
            rsp_rdata <= axi_rdata;
            rsp_resp  <= axi_rresp;
         end
         if ((state_q == WR_RESP) && axi_bvalid) begin
            rsp_resp <= axi_bresp;
         end
      end
   end

   // Handshake: a transfer happens on a posedge where valid and ready are both high; valids
   // are decoded from registered state only, so they hold with stable payload until accepted.
   assign axi_arvalid = (state_q == RD_ADDR);
   assign axi_rready  = (state_q == RD_DATA);
   assign axi_awvalid = (state_q == WR_REQ) && !aw_done_q;
   assign axi_wvalid  = (state_q == WR_REQ) && !w_done_q;
   assign axi_bready  = (state_q == WR_RESP);
   assign axi_araddr  = addr_q;
   assign axi_awaddr  = addr_q;
   assign axi_wdata   = wdata_q;
   assign axi_wstrb   = wstrb_q;
   assign axi_arprot  = PROT_VAL;
   assign axi_awprot  = PROT_VAL;
   assign busy        = (state_q != IDLE);
   assign ack         = (state_q == DONE) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
   assign dbg_state   = state_q;

endmodule
